mem_boot_loader: RTL and testbench
==================================

// Module: mem_boot_loader
// PURPOSE
//  Byte-stream program loader sitting directly upstream of the ideal memory write port.
//  Receives a framed byte stream (host/UART side), packs bytes into 32-bit words and drives the
//  memory's Waddr/Wren/Wdata. Holds the MIPS core in reset until a complete, checksum-valid
//  image has been written, then releases it. Replaces simulation-only initial-block loading.
// PARAMETERS
//  ADDR_WIDTH  10                      memory address width; must match the memory instance
//  MEM_WIDTH   2**(ADDR_WIDTH-2)       maximum word count accepted
// PORTS
//  clk       in   1           single clock; all logic on posedge
//  rst       in   1           synchronous, active-high reset
//  in_valid  in   1           byte-stream valid
//  in_data   in   8           byte-stream data
//  in_ready  out  1           loader can accept a byte
//  Waddr     out  ADDR_WIDTH  memory write word index (upper bits zero-extended)
//  Wren      out  1           memory write enable, one-cycle pulse per word
//  Wdata     out  32          memory write data
//  cpu_rst   out  1           reset to MIPS core; high until load is done
//  done      out  1           image loaded and checksum OK (sticky until rst)
//  error     out  1           length overflow or checksum mismatch (sticky until rst)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state<=LEN0, Waddr=0, Wdata=0, Wren=0, done=0, error=0, cpu_rst=1,
//    byte/word counters and checksum cleared. rst has priority over every other event.
//  - Handshake: a byte is consumed iff in_valid&&in_ready at posedge. in_data ignored otherwise.
//    in_ready=1 in LEN0, LEN1, DATA, CSUM; 0 in DONE, ERR, and during reset.
//  - Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), 4*N data bytes (each word
//    little-endian, first byte = bits[7:0]), one checksum byte = XOR of all preceding frame bytes.
//  - FSM: LEN0 -accept-> LEN1 -accept-> {ERR if N>MEM_WIDTH; CSUM if N==0; else DATA}.
//    DATA: after 4th byte of word k, registered write: next cycle Wren=1, Waddr=k, Wdata=word.
//    After word N-1 accepted -> CSUM. CSUM -accept-> DONE if byte==running XOR, else ERR.
//  - Write latency: Wren asserted exactly one cycle after the accept of a word's 4th byte; Wren
//    is a single-cycle pulse. No back-pressure from memory (ideal write). in_ready stays high
//    while the write is in flight; at most one write outstanding (4-byte minimum spacing).
//  - Word index counter is ADDR_WIDTH bits, runs 0..N-1, never wraps (N<=MEM_WIDTH enforced).
//  - DONE: done=1 and cpu_rst=0 from the cycle after checksum accept; held until rst.
//  - ERR: error=1, cpu_rst=1, in_ready=0, no further writes; held until rst. Words already
//    written remain in memory (not rolled back).
//  - Reset mid-frame: partial word discarded (never written), counters cleared, restart at LEN0.
//  - N==MEM_WIDTH is legal (fills memory exactly); N==MEM_WIDTH+1 is an error.
// STRUCTURE
//  - Shared header (mips_core defines include): FSM state encodings (LEN0, LEN1, DATA, CSUM,
//    DONE, ERR, 3-bit), frame-byte width constant.
//  - One sub-module: byte_word_packer (byte-lane shift/assemble + 2-bit byte counter, emits
//    word_valid pulse and 32-bit word). FSM, length check, checksum and write regs in top.
// TESTING
//  1. ADDR_WIDTH=10; bytes 02 00 01 00 1a 24 02 00 40 17 68, in_valid always 1 -> Wren pulses
//     with (Waddr=0, Wdata=0x241a0001) then (1, 0x17400002); done=1, cpu_rst=0 one cycle after 0x68.
//  2. Same frame, last byte 0x69 -> error=1, done=0, cpu_rst stays 1, in_ready=0; two writes done.
//  3. Frame 00 00 00 -> no Wren ever; done=1, cpu_rst=0.
//  4. Frame start 01 01 (N=257 > 256) -> error=1 after 2nd byte accepted; in_ready=0; no Wren.
//  5. Frame of test 1 with random in_valid gaps -> identical writes and done as test 1.
//  6. Send 02 00 01 00 1a, then rst=1 one cycle -> all outputs at reset values, no Wren;
//     then full frame of test 1 -> same result as test 1.

Source files
------------

// File: rtl/mem_boot_loader_pkg.sv
// Shared definitions for the byte-stream program loader.
// Holds loader FSM state encodings and frame constants.
package mem_boot_loader_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      ST_LEN0 = 3'd0,
      ST_LEN1 = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_e;

endpackage

// File: rtl/mem_boot_loader_byte_word_packer.sv
// Packs little-endian bytes into 32-bit words.
// word_vld_o is a same-cycle pulse on the accept of a word's 4th byte.
module byte_word_packer
   import mem_boot_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_vld_i,
   input  logic [BYTE_W-1:0] byte_i,
   output logic              word_vld_o,
   output logic [WORD_W-1:0] word_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] lanes_q, lanes_d;

   // Steer each accepted byte into its lane and advance the byte count.
   always_comb begin
      cnt_d   = cnt_q;
      lanes_d = lanes_q;
      if (byte_vld_i) begin
         cnt_d = cnt_q + 2'd1;
         unique case (cnt_q)
            2'd0: lanes_d[7:0]   = byte_i;
            2'd1: lanes_d[15:8]  = byte_i;
            2'd2: lanes_d[23:16] = byte_i;
            default: lanes_d     = '0;
         endcase
      end
   end

   // Lane and counter registers; reset drops any partial word.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         lanes_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         lanes_q <= lanes_d;
      end
   end

   assign word_vld_o = byte_vld_i && (cnt_q == 2'd3);
   assign word_o     = {byte_i, lanes_q};

endmodule

// File: rtl/mem_boot_loader.sv
// Framed byte-stream loader driving the memory write port.
// Holds the core in reset until a checksum-valid image is written.
module mem_boot_loader
   import mem_boot_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int MEM_WIDTH  = 2**(ADDR_WIDTH-2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [BYTE_W-1:0]     in_data,
   output logic                  in_ready,
   output logic [ADDR_WIDTH-1:0] Waddr,
   output logic                  Wren,
   output logic [WORD_W-1:0]     Wdata,
   output logic                  cpu_rst,
   output logic                  done,
   output logic                  error
);

   localparam logic [16:0] MEM_W = 17'(MEM_WIDTH);

   state_e                  state_q, state_d;
   logic [15:0]             len_q, len_d;
   logic [ADDR_WIDTH-1:0]   widx_q, widx_d;
   logic [BYTE_W-1:0]       csum_q, csum_d;
   logic                    wren_q, wren_d;
   logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
   logic [WORD_W-1:0]       wdata_q, wdata_d;

   logic                    accept;
   logic                    rdy_st;
   logic                    pk_vld;
   logic                    word_vld;
   logic [WORD_W-1:0]       word;
   logic [15:0]             len_full;
   logic                    last_word;

   assign rdy_st   = (state_q == ST_LEN0) || (state_q == ST_LEN1)
                  || (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign in_ready = !rst && rdy_st;
   assign accept   = in_valid && in_ready;
   assign pk_vld   = accept && (state_q == ST_DATA);
   assign len_full = {in_data, len_q[7:0]};
   assign last_word = (17'(widx_q) + 17'd1) == {1'b0, len_q};

   byte_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .byte_vld_i (pk_vld),
      .byte_i     (in_data),
      .word_vld_o (word_vld),
      .word_o     (word)
   );

   // Frame sequencing, length check and running checksum.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      widx_d  = widx_q;
      csum_d  = csum_q;
      if (accept) begin
         csum_d = csum_q ^ in_data;
      end
      unique case (state_q)
         ST_LEN0: begin
            if (accept) begin
               len_d[7:0] = in_data;
               state_d    = ST_LEN1;
            end
         end
         ST_LEN1: begin
            if (accept) begin
               len_d[15:8] = in_data;
               if ({1'b0, len_full} > MEM_W) begin
                  state_d = ST_ERR;
               end else if (len_full == 16'd0) begin
                  state_d = ST_CSUM;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (word_vld) begin
               if (last_word) begin
                  state_d = ST_CSUM;
               end else begin
                  widx_d = widx_q + 1'b1;
               end
            end
         end
         ST_CSUM: begin
            if (accept) begin
               state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
            end
         end
         ST_DONE: state_d = ST_DONE;
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_ERR;
      endcase
   end

   // Registered memory write: one-cycle pulse after a word completes.
   always_comb begin
      wren_d  = word_vld;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (word_vld) begin
         waddr_d = widx_q;
         wdata_d = word;
      end
   end

   // State, counter, checksum and write-port registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_LEN0;
         len_q   <= '0;
         widx_q  <= '0;
         csum_q  <= '0;
         wren_q  <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         widx_q  <= widx_d;
         csum_q  <= csum_d;
         wren_q  <= wren_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign Wren    = wren_q;
   assign Waddr   = waddr_q;
   assign Wdata   = wdata_q;
   assign done    = (state_q == ST_DONE);
   assign error   = (state_q == ST_ERR);
   assign cpu_rst = (state_q != ST_DONE);

endmodule

// File: tb/tb_mem_boot_loader.sv
// Randomized self-checking bench for mem_boot_loader.
// Frames are scored against a parse-level model of the frame format.
module tb_mem_boot_loader;

   localparam int AW   = 10;
   localparam int MEMW = 256;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic [AW-1:0] Waddr;
   logic          Wren;
   logic [31:0]   Wdata;
   logic          cpu_rst;
   logic          done;
   logic          error;

   int n_chk;
   int n_err;
   int cyc;
   int nacc_obs;

   logic [7:0]  frame[$];
   logic [31:0] exp_w[$];
   int          exp_c[$];
   int          got_a[$];
   logic [31:0] got_d[$];
   int          got_c[$];
   logic        m_done;
   logic        m_err;
   int          m_nacc;

   mem_boot_loader #(.ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .Waddr    (Waddr),
      .Wren     (Wren),
      .Wdata    (Wdata),
      .cpu_rst  (cpu_rst),
      .done     (done),
      .error    (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (Wren === 1'b1) begin
         got_a.push_back(int'(Waddr));
         got_d.push_back(Wdata);
         got_c.push_back(cyc);
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Parse-level reference: length, words, XOR checksum.
   task automatic model();
      int n;
      logic [7:0] x;
      exp_w.delete();
      n = int'(frame[1]) * 256 + int'(frame[0]);
      if (n > MEMW) begin
         m_nacc = 2;
         m_done = 1'b0;
         m_err  = 1'b1;
      end else begin
         x = 8'h00;
         for (int i = 0; i < 2 + 4 * n; i++) x = x ^ frame[i];
         for (int k = 0; k < n; k++) begin
            exp_w.push_back({frame[5+4*k], frame[4+4*k],
                             frame[3+4*k], frame[2+4*k]});
         end
         m_nacc = 3 + 4 * n;
         m_done = (frame[2+4*n] == x);
         m_err  = !m_done;
      end
   endtask

   task automatic apply_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rst_ready", in_ready, 0);
      check("rst_wren", Wren, 0);
      check("rst_waddr", Waddr, 0);
      check("rst_wdata", Wdata, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_cpurst", cpu_rst, 1);
      rst = 1'b0;
      #1;
   endtask

   task automatic send_frame(input int gap_pct);
      int i;
      int idle;
      int n;
      int budget;
      bit acc;
      i = 0;
      idle = 0;
      budget = 20000;
      n = int'(frame[1]) * 256 + int'(frame[0]);
      while (i < frame.size() && idle < 16 && budget > 0) begin
         budget--;
         if ($urandom_range(0, 99) < gap_pct) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
         end else begin
            in_valid = 1'b1;
            in_data  = frame[i];
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            if (i >= 2 && i < 2 + 4 * n && ((i - 2) % 4) == 3)
               exp_c.push_back(cyc);
            if (n <= MEMW && i == 2 + 4 * n) begin
               check("done_lat", done, m_done);
               check("cpurst_lat", cpu_rst, !m_done);
            end
            nacc_obs++;
            i++;
            idle = 0;
         end else if (in_valid) begin
            idle++;
         end
      end
      if (budget == 0) check("send_budget", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic run_frame(input bit do_rst, input int gap_pct);
      if (do_rst) apply_reset();
      got_a.delete();
      got_d.delete();
      got_c.delete();
      exp_c.delete();
      nacc_obs = 0;
      model();
      send_frame(gap_pct);
      repeat (4) @(posedge clk);
      #1;
      check("n_writes", got_a.size(), exp_w.size());
      check("n_wcyc", exp_c.size(), exp_w.size());
      for (int k = 0; k < exp_w.size(); k++) begin
         if (k < got_a.size()) begin
            check("waddr", got_a[k], k);
            check("wdata", got_d[k], exp_w[k]);
            if (k < exp_c.size())
               check("wlat", got_c[k], exp_c[k]);
         end
      end
      check("n_accept", nacc_obs, m_nacc);
      check("done", done, m_done);
      check("error", error, m_err);
      check("cpu_rst", cpu_rst, !m_done);
      check("ready_end", in_ready, 0);
   endtask

   task automatic build_frame(input int n, input bit bad);
      logic [7:0] x;
      logic [7:0] b;
      frame.delete();
      b = 8'(n);
      frame.push_back(b);
      b = 8'(n >> 8);
      frame.push_back(b);
      for (int i = 0; i < 4 * n; i++) begin
         b = 8'($urandom);
         frame.push_back(b);
      end
      x = 8'h00;
      foreach (frame[i]) x = x ^ frame[i];
      if (bad) x = x ^ 8'(1 + $urandom_range(0, 254));
      frame.push_back(x);
   endtask

   task automatic load_t1(input logic [7:0] last);
      frame = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h1a, 8'h24,
                8'h02, 8'h00, 8'h40, 8'h17, last};
   endtask

   initial begin
      n_chk    = 0;
      n_err    = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      nacc_obs = 0;
      repeat (2) @(posedge clk);
      #1;

      // Fixed frames from the frame-format examples.
      load_t1(8'h68);
      run_frame(1'b1, 0);
      check("t1_w0", (got_d.size() > 0) ? got_d[0] : 32'hx,
            32'h241a0001);
      check("t1_w1", (got_d.size() > 1) ? got_d[1] : 32'hx,
            32'h17400002);

      load_t1(8'h69);
      run_frame(1'b1, 0);

      frame = '{8'h00, 8'h00, 8'h00};
      run_frame(1'b1, 0);

      frame = '{8'h01, 8'h01, 8'h55, 8'h66, 8'h77};
      run_frame(1'b1, 0);

      load_t1(8'h68);
      run_frame(1'b1, 40);

      // Partial frame cut by reset, then a full frame.
      apply_reset();
      got_a.delete();
      frame = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h1a};
      foreach (frame[i]) begin
         in_valid = 1'b1;
         in_data  = frame[i];
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      apply_reset();
      repeat (3) @(posedge clk);
      #1;
      check("t6_no_wren", got_a.size(), 0);
      load_t1(8'h68);
      run_frame(1'b0, 0);

      // Capacity boundary: exact fill and one over.
      build_frame(MEMW, 1'b0);
      run_frame(1'b1, 10);
      frame = '{8'h01, 8'h01};
      run_frame(1'b1, 0);
      build_frame(0, 1'b1);
      run_frame(1'b1, 20);

      // Random frames, random gaps, some corrupt checksums.
      for (int t = 0; t < 12; t++) begin
         build_frame($urandom_range(0, 7),
                     ($urandom_range(0, 3) == 0));
         run_frame(1'b1, $urandom_range(0, 60));
      end
      for (int t = 0; t < 3; t++) begin
         build_frame(0, 1'b0);
         frame[1] = 8'($urandom_range(2, 255));
         frame.push_back(8'($urandom));
         run_frame(1'b1, 20);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
